// File: rtl/mini_cpu_core.sv
// Multi-cycle parametrised core: ADD/LOAD/STORE/BRANCH with req/ack instruction fetch.
// Build option: define MP_BRANCH_COND_EN to make op 11 a BEQ (rs == rt); otherwise branches are unconditional.
module mini_cpu_core #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned NREGS      = 4,
  parameter int unsigned DMEM_DEPTH = 32,
  parameter int unsigned PC_W       = 8,
  localparam int unsigned RA_W      = $clog2(NREGS),
  localparam int unsigned IW        = 2 + 3 * RA_W
) (
  input  logic              clock,
  input  logic              reset,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [IW-1:0]     imem_data,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic [15:0]       retired
);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_EXEC  = 2'd1;
  localparam logic [1:0] S_MEM   = 2'd2;
  localparam logic [1:0] S_WB    = 2'd3;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;
  localparam logic [1:0] OP_BR    = 2'b11;

  localparam int unsigned DM_AW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

  logic [1:0]        state;
  logic [1:0]        state_nx;
  logic              req_q;
  logic [PC_W-1:0]   pc;
  logic [PC_W-1:0]   pc_nx;
  logic [IW-1:0]     ir;
  logic [DATA_W-1:0] mar;
  logic [DATA_W-1:0] mdr;
  logic [15:0]       retired_q;
  logic              wb_valid_q;
  logic [DATA_W-1:0] wb_data_q;

  logic [DATA_W-1:0] regs [NREGS];
  logic [DATA_W-1:0] dmem [DMEM_DEPTH];

  // Instruction decode
  logic [1:0]        op;
  logic [RA_W-1:0]   rs_a;
  logic [RA_W-1:0]   rt_a;
  logic [RA_W-1:0]   rd_a;
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;
  logic [DATA_W-1:0] imm_d;
  logic [PC_W-1:0]   imm_pc;
  logic [DATA_W-1:0] alu;

  assign op     = ir[IW-1 -: 2];
  assign rs_a   = ir[IW-3 -: RA_W];
  assign rt_a   = ir[IW-3-RA_W -: RA_W];
  assign rd_a   = ir[RA_W-1:0];
  assign rs_val = regs[rs_a];
  assign rt_val = regs[rt_a];
  assign imm_d  = {{(DATA_W-RA_W){rd_a[RA_W-1]}}, rd_a};
  assign imm_pc = {{(PC_W-RA_W){rd_a[RA_W-1]}}, rd_a};
  assign alu    = rs_val + ((op == OP_ADD) ? rt_val : imm_d);

  // Data-memory range checks on the full address, so out-of-range never aliases
  logic alu_in_range;
  logic mar_in_range;
  assign alu_in_range = ((DATA_W+1)'(alu) < (DATA_W+1)'(DMEM_DEPTH));
  assign mar_in_range = ((DATA_W+1)'(mar) < (DATA_W+1)'(DMEM_DEPTH));

  logic br_taken;
`ifdef MP_BRANCH_COND_EN
  assign br_taken = (rs_val == rt_val);
`else
  assign br_taken = 1'b1;
`endif

  // Control strobes
  logic in_exec;
  logic fetch_fire;
  logic retire;
  logic wr_en;
  logic [RA_W-1:0]   wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic st_en;

  assign in_exec    = (state == S_EXEC);
  assign fetch_fire = (state == S_FETCH) && req_q && imem_ack;
  assign retire     = (in_exec && (op != OP_LOAD)) || (state == S_WB);
  assign wr_en      = (in_exec && (op == OP_ADD)) || (state == S_WB);
  assign wr_addr    = (state == S_WB) ? rt_a : rd_a;
  assign wr_data    = (state == S_WB) ? mdr : alu;
  assign st_en      = in_exec && (op == OP_STORE) && alu_in_range;

  always_comb begin
    pc_nx = pc + PC_W'(1);
    if (in_exec && (op == OP_BR) && br_taken)
      pc_nx = pc + PC_W'(1) + imm_pc;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_FETCH: if (fetch_fire) state_nx = S_EXEC;
      S_EXEC:  state_nx = (op == OP_LOAD) ? S_MEM : S_FETCH;
      S_MEM:   state_nx = S_WB;
      S_WB:    state_nx = S_FETCH;
      default: state_nx = S_FETCH;
    endcase
  end

  // imem_req is registered so it stays low through the reset cycle
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_FETCH;
      req_q      <= 1'b0;
      pc         <= '0;
      ir         <= '0;
      mar        <= '0;
      mdr        <= '0;
      retired_q  <= '0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
    end else begin
      state      <= state_nx;
      req_q      <= (state_nx == S_FETCH);
      wb_valid_q <= wr_en;
      if (fetch_fire)
        ir <= imem_data;
      if (in_exec)
        mar <= alu;
      if (state == S_MEM)
        mdr <= mar_in_range ? dmem[mar[DM_AW-1:0]] : '0;
      if (wr_en)
        wb_data_q <= wr_data;
      if (retire) begin
        retired_q <= retired_q + 16'd1;
        pc        <= pc_nx;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREGS; i++)
        regs[i] <= '0;
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DMEM_DEPTH; i++)
        dmem[i] <= DATA_W'(i);
    end else if (st_en) begin
      dmem[alu[DM_AW-1:0]] <= rt_val;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = pc;
  assign wb_valid  = wb_valid_q;
  assign wb_data   = wb_data_q;
  assign retired   = retired_q;

endmodule
